led7seg_capture: RTL

//  Receive side of the 4-digit multiplexed 7-segment display bus (LED[7:0] segments, SA[3:0] digit select).

---
 rtl/led7seg_capture.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/led7seg_capture.sv
// Receive side of a 4-digit multiplexed 7-segment bus: synchronizes, debounces and
// decodes each scanned digit back to a hex nibble, with DP/blank/seen/frame/error status.
module led7seg_capture #(
  parameter int SETTLE = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  led_i,
  input  logic [3:0]  sa_i,
  input  logic        clr_i,
  output logic [15:0] digits_o,
  output logic [3:0]  dp_o,
  output logic [3:0]  blank_o,
  output logic [3:0]  seen_o,
  output logic        frame_o,
  output logic        badSeg_o,
  output logic        badSel_o
);

  localparam int CW = $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SettleCnt   = CW'(SETTLE);
  localparam logic [CW-1:0] SettleCntM1 = CW'(SETTLE - 1);

  logic [7:0]    ledMeta_q, ledSync_q;
  logic [3:0]    saMeta_q, saSync_q;
  logic          vldMeta_q, vldSync_q, prevValid_q;
  logic [11:0]   busPrev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          capture;
  logic          stable;

  logic [15:0]   digits_q, digits_d;
  logic [3:0]    dp_q, dp_d;
  logic [3:0]    blank_q, blank_d;
  logic [3:0]    seen_q, seen_d;
  logic          frame_q, frame_d;
  logic          badSeg_q, badSeg_d;
  logic          badSel_q, badSel_d;

  logic [6:0]    seg;
  logic [4:0]    glyph;
  logic [3:0]    selAct;
  logic          oneHot;
  logic          multiSel;
  logic          isBlank;
  logic          goodData;
  logic          badData;
  logic [3:0]    seenMerged;

  // Returns {valid, nibble}; valid=0 for anything that is not a hex glyph.
  function automatic logic [4:0] decodeGlyph(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      7'h3F: r = 5'h10;
      7'h06: r = 5'h11;
      7'h5B: r = 5'h12;
      7'h4F: r = 5'h13;
      7'h66: r = 5'h14;
      7'h6D: r = 5'h15;
      7'h7D: r = 5'h16;
      7'h07: r = 5'h17;
      7'h7F: r = 5'h18;
      7'h6F: r = 5'h19;
      7'h77: r = 5'h1A;
      7'h7C: r = 5'h1B;
      7'h39: r = 5'h1C;
      7'h5E: r = 5'h1D;
      7'h79: r = 5'h1E;
      7'h71: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // The valid bits track when the sync and compare stages hold real samples, so the
  // all-zero reset contents of the synchronizer are never mistaken for a settled pattern.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ledMeta_q   <= '0;
      ledSync_q   <= '0;
      saMeta_q    <= '0;
      saSync_q    <= '0;
      vldMeta_q   <= 1'b0;
      vldSync_q   <= 1'b0;
      prevValid_q <= 1'b0;
      busPrev_q   <= '0;
      cnt_q       <= '0;
    end else begin
      ledMeta_q   <= led_i;
      ledSync_q   <= ledMeta_q;
      saMeta_q    <= sa_i;
      saSync_q    <= saMeta_q;
      vldMeta_q   <= 1'b1;
      vldSync_q   <= vldMeta_q;
      prevValid_q <= vldSync_q;
      busPrev_q   <= {saSync_q, ledSync_q};
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    stable  = prevValid_q && ({saSync_q, ledSync_q} == busPrev_q);
    cnt_d   = cnt_q;
    capture = 1'b0;
    if (!vldSync_q) begin
      cnt_d = '0;
    end else if (!stable) begin
      cnt_d   = CW'(1);
      capture = (SETTLE == 1);
    end else begin
      if (cnt_q != SettleCnt) begin
        cnt_d = cnt_q + CW'(1);
      end
      capture = (cnt_q == SettleCntM1);
    end
  end

  always_comb begin
    seg      = ~ledSync_q[6:0];
    glyph    = decodeGlyph(seg);
    isBlank  = (seg == 7'h00);
    selAct   = ~saSync_q;
    oneHot   = (selAct != 4'h0) && ((selAct & (selAct - 4'd1)) == 4'h0);
    multiSel = (selAct != 4'h0) && !oneHot;
    goodData = capture && oneHot && (glyph[4] || isBlank);
    badData  = capture && oneHot && !glyph[4] && !isBlank;
  end

  // Data fields are written even when clr_i coincides with a capture; only status is cleared.
  always_comb begin
    digits_d   = digits_q;
    dp_d       = dp_q;
    blank_d    = blank_q;
    for (int i = 0; i < 4; i++) begin
      if (goodData && selAct[i]) begin
        dp_d[i] = ~ledSync_q[7];
        if (glyph[4]) begin
          digits_d[4*i +: 4] = glyph[3:0];
          blank_d[i]         = 1'b0;
        end else begin
          blank_d[i] = 1'b1;
        end
      end
    end

    seenMerged = seen_q | (goodData ? selAct : 4'h0);
    seen_d     = seenMerged;
    frame_d    = 1'b0;
    badSeg_d   = badSeg_q | badData;
    badSel_d   = badSel_q | (capture && multiSel);
    if (clr_i) begin
      seen_d   = 4'h0;
      badSeg_d = 1'b0;
      badSel_d = 1'b0;
    end else if (seenMerged == 4'hF) begin
      seen_d  = 4'h0;
      frame_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      digits_q <= '0;
      dp_q     <= '0;
      blank_q  <= '0;
      seen_q   <= '0;
      frame_q  <= 1'b0;
      badSeg_q <= 1'b0;
      badSel_q <= 1'b0;
    end else begin
      digits_q <= digits_d;
      dp_q     <= dp_d;
      blank_q  <= blank_d;
      seen_q   <= seen_d;
      frame_q  <= frame_d;
      badSeg_q <= badSeg_d;
      badSel_q <= badSel_d;
    end
  end

  assign digits_o = digits_q;
  assign dp_o     = dp_q;
  assign blank_o  = blank_q;
  assign seen_o   = seen_q;
  assign frame_o  = frame_q;
  assign badSeg_o = badSeg_q;
  assign badSel_o = badSel_q;

endmodule
